// File: rtl/st_h2c_mq_chk_if.sv
// H2C AXI-Stream bundle for the multi-queue pattern checker.
//   master : traffic source (drives data/sideband, observes tready)
//   slave  : checker (observes data/sideband, drives tready)
// Signals: tdata, tvalid, tlast, tuser_qid (11), tuser_mty (6, empty bytes on last beat),
//          tuser_zero_byte, tuser_err, tready.
interface st_h2c_mq_chk_if #(
  parameter int unsigned BIT_WIDTH = 256
) ();
  logic [BIT_WIDTH-1:0] tdata;
  logic                 tvalid;
  logic                 tlast;
  logic [10:0]          tuser_qid;
  logic [5:0]           tuser_mty;
  logic                 tuser_zero_byte;
  logic                 tuser_err;
  logic                 tready;

  modport master (
    output tdata, tvalid, tlast, tuser_qid, tuser_mty, tuser_zero_byte, tuser_err,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tuser_qid, tuser_mty, tuser_zero_byte, tuser_err,
    output tready
  );
endinterface

// File: rtl/st_h2c_mq_chk.sv
// Multi-queue H2C stream checker. Each packet must carry a 16-bit incrementing pattern
// starting at 0; per-queue packet/error counters, first-error capture and an overall
// match flag are kept. An LFSR optionally throttles tready.
// Ports:
//   axi_aclk, axi_areset  : clock, synchronous active-high reset
//   control_reg           : bit0 loopback (checking off), bit1 back-pressure enable
//   clr_match             : clear all status/counters
//   h2c_txr_size          : expected packet length in bytes, 0 disables the length check
//   h2c                   : stream slave port
//   stat_qid              : counter readback select
//   stat_pkt_cnt/err_cnt  : registered counters of the selected queue
//   h2c_match             : at least one packet seen and no error captured
//   first_err_vld/qid/code: first errored packet (sticky until clear)
module st_h2c_mq_chk #(
  parameter int unsigned BIT_WIDTH  = 256,
  parameter int unsigned NUM_Q      = 8,
  parameter int unsigned PATT_WIDTH = 16,
  localparam int unsigned QW        = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
  input  logic                  axi_aclk,
  input  logic                  axi_areset,
  input  logic [31:0]           control_reg,
  input  logic                  clr_match,
  input  logic [31:0]           h2c_txr_size,
  st_h2c_mq_chk_if.slave        h2c,
  input  logic [QW-1:0]         stat_qid,
  output logic [31:0]           stat_pkt_cnt,
  output logic [15:0]           stat_err_cnt,
  output logic                  h2c_match,
  output logic                  first_err_vld,
  output logic [10:0]           first_err_qid,
  output logic [2:0]            first_err_code
);

  localparam int unsigned BYTES     = BIT_WIDTH / 8;
  localparam int unsigned PattBytes = PATT_WIDTH / 8;
  localparam logic [15:0] BeatWords = 16'(BYTES / PattBytes);

  typedef enum logic [0:0] {StSop, StMid} state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        tready_q;
  logic [10:0] qid_q, qid_d;
  logic [19:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] word_q, word_d;
  logic        data_err_q, data_err_d;
  logic        user_err_q, user_err_d;
  logic        zero_q, zero_d;

  logic [31:0] pkt_cnt_q [NUM_Q];
  logic [15:0] err_cnt_q [NUM_Q];
  logic        fev_q;
  logic [10:0] fqid_q;
  logic [2:0]  fcode_q;
  logic        match_q;
  logic [31:0] stat_pkt_q;
  logic [15:0] stat_err_q;

  logic        accept, sop, done;
  logic [10:0] pkt_qid;
  logic [15:0] word_cur;
  logic [19:0] beats_cur;
  logic [5:0]  mty_eff;
  int unsigned valid_bytes;
  logic [15:0] patt_w;
  logic [7:0]  exp_byte;
  logic        data_err_beat;
  logic        data_err_any, user_err_any, zero_any;
  logic [19:0] pkt_len;
  logic [2:0]  code;
  logic        any_pkt;
  logic [31:0] sel_pkt;
  logic [15:0] sel_err;

  logic unused_ctrl;
  assign unused_ctrl = ^control_reg[31:2];

  assign h2c.tready     = tready_q;
  assign stat_pkt_cnt   = stat_pkt_q;
  assign stat_err_cnt   = stat_err_q;
  assign h2c_match      = match_q;
  assign first_err_vld  = fev_q;
  assign first_err_qid  = fqid_q;
  assign first_err_code = fcode_q;

  assign accept = h2c.tvalid & tready_q;
  assign sop    = (state_q == StSop);
  // Packet-level context: values from the first beat, or accumulated ones on later beats.
  assign pkt_qid   = sop ? h2c.tuser_qid : qid_q;
  assign word_cur  = sop ? 16'd0 : word_q;
  assign beats_cur = (sop ? 20'd0 : beat_cnt_q) + 20'd1;
  assign lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  // Per-beat pattern check and packet summary
  always_comb begin
    mty_eff       = (32'(h2c.tuser_mty) >= BYTES) ? 6'(BYTES - 1) : h2c.tuser_mty;
    valid_bytes   = h2c.tuser_zero_byte ? 0 : (h2c.tlast ? BYTES - 32'(mty_eff) : BYTES);
    data_err_beat = 1'b0;
    patt_w        = 16'd0;
    exp_byte      = 8'd0;
    for (int unsigned j = 0; j < BYTES; j++) begin
      patt_w   = word_cur + 16'(j / PattBytes);
      exp_byte = ((j % PattBytes) == 0) ? patt_w[7:0] : patt_w[15:8];
      if ((j < valid_bytes) && (h2c.tdata[8*j +: 8] != exp_byte)) begin
        data_err_beat = 1'b1;
      end
    end
    data_err_any = (!sop && data_err_q) | data_err_beat;
    user_err_any = (!sop && user_err_q) | h2c.tuser_err;
    zero_any     = (!sop && zero_q) | h2c.tuser_zero_byte;
    pkt_len      = zero_any ? 20'd0 : (beats_cur * 20'(BYTES) - 20'(mty_eff));

    code = 3'd0;
    if (32'(pkt_qid) >= NUM_Q) begin
      code = 3'd4;
    end else if (user_err_any) begin
      code = 3'd3;
    end else if (data_err_any) begin
      code = 3'd1;
    end else if ((h2c_txr_size != 32'd0) && (pkt_len != h2c_txr_size[19:0])) begin
      code = 3'd2;
    end
  end

  // Completion updates status; clear wins over a coincident completion
  assign done = accept & h2c.tlast & ~control_reg[0] & ~clr_match;

  always_comb begin
    state_d    = state_q;
    qid_d      = qid_q;
    beat_cnt_d = beat_cnt_q;
    word_d     = word_q;
    data_err_d = data_err_q;
    user_err_d = user_err_q;
    zero_d     = zero_q;
    if (accept) begin
      state_d    = h2c.tlast ? StSop : StMid;
      qid_d      = pkt_qid;
      beat_cnt_d = beats_cur;
      word_d     = word_cur + BeatWords;
      data_err_d = data_err_any;
      user_err_d = user_err_any;
      zero_d     = zero_any;
    end
    if (clr_match) begin
      state_d = StSop;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q    <= StSop;
      lfsr_q     <= 16'h0011;
      tready_q   <= 1'b1;
      qid_q      <= '0;
      beat_cnt_q <= '0;
      word_q     <= '0;
      data_err_q <= 1'b0;
      user_err_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      tready_q   <= ~(control_reg[1] & lfsr_q[0]);
      qid_q      <= qid_d;
      beat_cnt_q <= beat_cnt_d;
      word_q     <= word_d;
      data_err_q <= data_err_d;
      user_err_q <= user_err_d;
      zero_q     <= zero_d;
    end
  end

  always_comb begin
    any_pkt = 1'b0;
    sel_pkt = '0;
    sel_err = '0;
    for (int unsigned q = 0; q < NUM_Q; q++) begin
      any_pkt = any_pkt | (pkt_cnt_q[q] != 32'd0);
      if (32'(stat_qid) == q) begin
        sel_pkt = pkt_cnt_q[q];
        sel_err = err_cnt_q[q];
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset || clr_match) begin
      for (int unsigned q = 0; q < NUM_Q; q++) begin
        pkt_cnt_q[q] <= '0;
        err_cnt_q[q] <= '0;
      end
      fev_q      <= 1'b0;
      fqid_q     <= '0;
      fcode_q    <= '0;
      match_q    <= 1'b0;
      stat_pkt_q <= '0;
      stat_err_q <= '0;
    end else begin
      if (done && (code != 3'd4)) begin
        for (int unsigned q = 0; q < NUM_Q; q++) begin
          if (32'(pkt_qid) == q) begin
            pkt_cnt_q[q] <= pkt_cnt_q[q] + 32'd1;
            if ((code != 3'd0) && (err_cnt_q[q] != 16'hFFFF)) begin
              err_cnt_q[q] <= err_cnt_q[q] + 16'd1;
            end
          end
        end
      end
      if (done && (code != 3'd0) && !fev_q) begin
        fev_q   <= 1'b1;
        fqid_q  <= pkt_qid;
        fcode_q <= code;
      end
      match_q    <= any_pkt & ~fev_q;
      stat_pkt_q <= sel_pkt;
      stat_err_q <= sel_err;
    end
  end

endmodule

// File: tb/tb_st_h2c_mq_chk.sv
// Randomized self-checking bench for st_h2c_mq_chk (256-bit, 8 queues). Expected status is
// derived per packet from its generation parameters (length, corrupted offset, qid, flags).
module tb_st_h2c_mq_chk;
  localparam int unsigned BW    = 256;
  localparam int unsigned NQ    = 8;
  localparam int unsigned BYTES = BW / 8;
  localparam int unsigned QW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   control_reg = '0;
  logic          clr_match = 1'b0;
  logic [31:0]   h2c_txr_size = '0;
  logic [QW-1:0] stat_qid = '0;
  logic [31:0]   stat_pkt_cnt;
  logic [15:0]   stat_err_cnt;
  logic          h2c_match, first_err_vld;
  logic [10:0]   first_err_qid;
  logic [2:0]    first_err_code;

  always #5 clk = ~clk;

  st_h2c_mq_chk_if #(.BIT_WIDTH(BW)) h2c ();

  st_h2c_mq_chk #(.BIT_WIDTH(BW), .NUM_Q(NQ), .PATT_WIDTH(16)) dut (
    .axi_aclk       (clk),
    .axi_areset     (rst),
    .control_reg    (control_reg),
    .clr_match      (clr_match),
    .h2c_txr_size   (h2c_txr_size),
    .h2c            (h2c),
    .stat_qid       (stat_qid),
    .stat_pkt_cnt   (stat_pkt_cnt),
    .stat_err_cnt   (stat_err_cnt),
    .h2c_match      (h2c_match),
    .first_err_vld  (first_err_vld),
    .first_err_qid  (first_err_qid),
    .first_err_code (first_err_code)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference status
  int unsigned m_pkt [NQ];
  int unsigned m_err [NQ];
  bit          m_fev;
  int unsigned m_fqid, m_fcode;

  function automatic void model_clear();
    for (int q = 0; q < NQ; q++) begin
      m_pkt[q] = 0;
      m_err[q] = 0;
    end
    m_fev = 0; m_fqid = 0; m_fcode = 0;
  endfunction

  // Back-pressure reference: ready for the next cycle comes from the current LFSR bit 0
  logic [15:0] m_lfsr   = 16'h0011;
  logic        m_tready = 1'b1;
  bit          lfsr_chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_lfsr   <= 16'h0011;
      m_tready <= 1'b1;
    end else begin
      m_tready <= ~(control_reg[1] & m_lfsr[0]);
      m_lfsr   <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  end

  always @(negedge clk) begin
    if (lfsr_chk_en) check_eq("tready_lfsr", h2c.tready, m_tready);
  end

  function automatic logic [BW-1:0] patt_beat(input int beat);
    logic [BW-1:0] d;
    logic [15:0]   w;
    int            k;
    for (int j = 0; j < BYTES; j++) begin
      k = beat * BYTES + j;
      w = 16'(k / 2);
      d[8*j +: 8] = (k % 2 == 0) ? w[7:0] : w[15:8];
    end
    return d;
  endfunction

  task automatic send_beat(input logic [BW-1:0] d, input bit last, input int qid, input int mty,
                           input bit zero, input bit uerr, input bit clr);
    int wait_n;
    @(negedge clk);
    h2c.tdata           = d;
    h2c.tlast           = last;
    h2c.tuser_qid       = 11'(qid);
    h2c.tuser_mty       = 6'(mty);
    h2c.tuser_zero_byte = zero;
    h2c.tuser_err       = uerr;
    h2c.tvalid          = 1'b1;
    clr_match           = clr;
    wait_n = 0;
    while (h2c.tready !== 1'b1 && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    if (wait_n >= 200) check_eq("tready_timeout", h2c.tready, 1);
  endtask

  task automatic end_pkt();
    @(negedge clk);
    h2c.tvalid = 1'b0;
    h2c.tlast  = 1'b0;
    clr_match  = 1'b0;
  endtask

  // Sends one packet and folds its expected outcome into the reference status
  task automatic send_pkt(input int qid, input int nbeats, input int mty, input int corrupt,
                          input int uerr_beat, input bit zero, input logic [31:0] txr,
                          input bit clr_last);
    logic [BW-1:0] d;
    int mty_eff, len, code, nb;
    bit derr, uerr;
    nb = zero ? 1 : nbeats;
    h2c_txr_size = txr;
    for (int b = 0; b < nb; b++) begin
      d = zero ? {8{$urandom()}} : patt_beat(b);
      if (corrupt >= b * BYTES && corrupt < (b + 1) * BYTES)
        d[8*(corrupt - b*BYTES) +: 8] = d[8*(corrupt - b*BYTES) +: 8] ^ 8'h5A;
      send_beat(d, b == nb - 1, (b == 0) ? qid : int'($urandom_range(0, 2047)),
                (b == nb - 1) ? mty : int'($urandom_range(0, 63)), zero, b == uerr_beat,
                clr_last && (b == nb - 1));
    end
    end_pkt();
    mty_eff = (mty >= BYTES) ? BYTES - 1 : mty;
    len  = zero ? 0 : nb * BYTES - mty_eff;
    derr = !zero && corrupt >= 0 && corrupt < len;
    uerr = uerr_beat >= 0 && uerr_beat < nb;
    if (qid >= NQ)                            code = 4;
    else if (uerr)                            code = 3;
    else if (derr)                            code = 1;
    else if (txr != 0 && len != int'(txr[19:0])) code = 2;
    else                                      code = 0;
    if (control_reg[0]) begin
      // checking disabled: no status change
    end else if (clr_last) begin
      model_clear();
    end else begin
      if (code != 4) begin
        m_pkt[qid]++;
        if (code != 0 && m_err[qid] < 16'hFFFF) m_err[qid]++;
      end
      if (code != 0 && !m_fev) begin
        m_fev = 1; m_fqid = qid; m_fcode = code;
      end
    end
  endtask

  task automatic check_all(input string tag);
    bit any;
    any = 0;
    @(negedge clk);
    for (int q = 0; q < NQ; q++) begin
      @(negedge clk);
      stat_qid = QW'(q);
      @(negedge clk);
      check_eq($sformatf("%s pkt_cnt[%0d]", tag, q), stat_pkt_cnt, m_pkt[q]);
      check_eq($sformatf("%s err_cnt[%0d]", tag, q), stat_err_cnt, m_err[q]);
      if (m_pkt[q] != 0) any = 1;
    end
    check_eq({tag, " first_err_vld"},  first_err_vld,  m_fev);
    check_eq({tag, " first_err_qid"},  first_err_qid,  m_fqid);
    check_eq({tag, " first_err_code"}, first_err_code, m_fcode);
    check_eq({tag, " h2c_match"},      h2c_match,      any && !m_fev);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr_match = 1'b1;
    @(negedge clk);
    clr_match = 1'b0;
    model_clear();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    h2c.tvalid = 1'b0;
    h2c.tlast  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  int qid, nb, mty, len, corrupt, uerr_b;
  bit zero;
  logic [31:0] txr;

  initial begin
    h2c.tdata = '0; h2c.tvalid = 1'b0; h2c.tlast = 1'b0; h2c.tuser_qid = '0;
    h2c.tuser_mty = '0; h2c.tuser_zero_byte = 1'b0; h2c.tuser_err = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lfsr_chk_en = 1;
    check_eq("reset tready", h2c.tready, 1);
    check_all("reset");

    // Clean 4-beat packet, then a corrupted one on another queue
    send_pkt(2, 4, 0, -1, -1, 0, 32'd128, 0);
    check_all("good_q2");
    send_pkt(5, 4, 0, 37, -1, 0, 32'd128, 0);
    check_all("corrupt_q5");

    // Garbage in the empty bytes is ignored; the length check still applies
    do_clear();
    check_all("clear");
    send_pkt(3, 3, 10, 90, -1, 0, 32'd86, 0);
    check_all("mty_ok");
    send_pkt(3, 3, 10, 90, -1, 0, 32'd96, 0);
    check_all("mty_len_err");

    // Out-of-range queue, then zero-byte packet
    do_clear();
    send_pkt(9, 2, 0, -1, -1, 0, 32'd0, 0);
    check_all("bad_qid");
    do_clear();
    send_pkt(1, 1, 0, -1, -1, 1, 32'd0, 0);
    check_all("zero_byte");
    send_pkt(4, 2, 0, -1, 1, 0, 32'd0, 0);
    check_all("tuser_err");

    // Loopback: nothing is checked or counted
    control_reg = 32'h1;
    send_pkt(6, 2, 0, 5, -1, 0, 32'd7, 0);
    control_reg = 32'h0;
    check_all("loopback");
    send_pkt(0, 1, BYTES + 3, -1, -1, 0, 32'd1, 0);
    check_all("mty_clamp");

    // Back-pressure with clean random packets
    do_clear();
    control_reg = 32'h2;
    for (int p = 0; p < 100; p++) begin
      qid = $urandom_range(0, NQ - 1);
      nb  = $urandom_range(1, 4);
      mty = $urandom_range(0, BYTES - 1);
      len = nb * BYTES - mty;
      txr = ($urandom_range(0, 1) == 1) ? 32'(len) : 32'd0;
      send_pkt(qid, nb, mty, -1, -1, 0, txr, 0);
      if (p % 10 == 9) check_all("bp_pass");
    end

    // Clear coincident with the last beat
    control_reg = 32'h0;
    send_pkt(7, 2, 0, -1, -1, 0, 32'd0, 1);
    check_all("clr_on_tlast");

    // Random error mix under back-pressure
    control_reg = 32'h2;
    for (int p = 0; p < 40; p++) begin
      qid     = $urandom_range(0, NQ + 3);
      nb      = $urandom_range(1, 4);
      mty     = $urandom_range(0, 40);
      zero    = ($urandom_range(0, 9) == 0);
      corrupt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb * BYTES - 1)) : -1;
      uerr_b  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      len     = nb * BYTES - ((mty >= BYTES) ? BYTES - 1 : mty);
      case ($urandom_range(0, 2))
        0:       txr = 32'd0;
        1:       txr = 32'(len);
        default: txr = 32'(len + 1);
      endcase
      send_pkt(qid, nb, mty, corrupt, uerr_b, zero, txr, 0);
      check_all("rand_err");
      if (p == 20) do_clear();
    end

    // Reset in the middle of a packet
    control_reg = 32'h0;
    send_beat(patt_beat(0), 0, 4, 0, 0, 0, 0);
    send_beat(patt_beat(1), 0, 4, 0, 0, 0, 0);
    do_reset();
    send_pkt(6, 2, 0, -1, -1, 0, 32'd64, 0);
    check_all("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/st_h2c_mq_chk.md
ST_H2C_MQ_CHK -- requirements
Module: st_h2c_mq_chk

Interface
REQ-001 Parameter BIT_WIDTH, default 256, tdata width; SHALL be 64, 128, 256 or 512; BYTES = BIT_WIDTH/8.
REQ-002 Parameter NUM_Q, default 8, checked queues; power of 2, 1..16; QW = max(1, log2(NUM_Q)).
REQ-003 Parameter PATT_WIDTH, default 16, pattern word width; only 16 supported.
REQ-004 Ports SHALL be: axi_aclk in 1 clock; axi_areset in 1 synchronous active-high reset; control_reg in 32 (bit0 loopback = checking off, bit1 back-pressure enable); clr_match in 1 clear all status; h2c_txr_size in 32 expected packet bytes (0 = no length check).
REQ-005 Stream ports: h2c_tdata in BIT_WIDTH; h2c_tvalid in 1; h2c_tlast in 1; h2c_tuser_qid in 11; h2c_tuser_mty in 6 empty bytes on last beat; h2c_tuser_zero_byte in 1; h2c_tuser_err in 1; h2c_tready out 1.
REQ-006 Status ports: stat_qid in QW readback select; stat_pkt_cnt out 32; stat_err_cnt out 16; h2c_match out 1; first_err_vld out 1; first_err_qid out 11; first_err_code out 3.

Function
REQ-007 Beat accepted when h2c_tvalid & h2c_tready; no state changes on non-accepted cycles.
REQ-008 FSM states SOP and MID; SOP->MID on accepted beat with tlast=0; MID->SOP on accepted tlast; SOP stays on single-beat packet.
REQ-009 On SOP beat, qid, beat count and word counter SHALL be latched; qid applies to whole packet; tuser_qid ignored on MID beats.
REQ-010 Expected data: packet byte offset k = beat*BYTES + j SHALL equal word w=k/2 of 16-bit incrementing pattern starting at 0 each packet; byte 2w = w[7:0], 2w+1 = w[15:8]; w wraps modulo 2^16.
REQ-011 On tlast beat only bytes j < BYTES-mty checked; mty >= BYTES on tlast treated as mty=BYTES-1 (1 valid byte).
REQ-012 zero_byte beat: no data check; packet length = 0.
REQ-013 Packet length = beats*BYTES - mty (20-bit); length error when h2c_txr_size != 0 and length != h2c_txr_size[19:0].
REQ-014 Error codes, priority high to low: 4 qid >= NUM_Q; 3 tuser_err on any beat; 1 data mismatch on any beat; 2 length mismatch; 0 none.
REQ-015 Per queue: pkt_cnt (32, wraps) increments once per packet; err_cnt (16, saturates 0xFFFF) increments once per errored packet; code-4 packets update no queue counters.
REQ-016 Counter update and first-error capture SHALL occur the cycle after the accepted tlast beat (latency 1).
REQ-017 first_err_vld sticky; first_err_qid/code capture first errored packet only; later errors ignored until clear.
REQ-018 h2c_match = (sum pkt_cnt over queues > 0) & ~first_err_vld, registered.
REQ-019 stat_pkt_cnt/stat_err_cnt registered, valid 1 cycle after stat_qid; includes updates from previous cycle.
REQ-020 control_reg[0]=1: no checks, no counter/status updates; FSM still tracks packet boundaries.
REQ-021 Back pressure: 16-bit LFSR seed 0x0011, shift right each cycle, new MSB = b0^b2^b3^b5; h2c_tready next cycle = ~(control_reg[1] & lfsr[0]).
REQ-022 clr_match: clears counters, first_err_*, h2c_match next cycle, FSM to SOP; wins over simultaneous packet completion; LFSR unaffected.

Reset
REQ-023 axi_areset: FSM SOP, all counters 0, first_err_vld 0, first_err_qid 0, first_err_code 0, h2c_match 0, stat outputs 0, h2c_tready 1, LFSR 0x0011.
REQ-024 Reset mid-packet: partial packet discarded, next accepted beat treated as SOP.

Verification
REQ-025 BIT_WIDTH=256, qid 2, 4-beat pattern packet, mty=0, txr_size 128 -> q2 pkt_cnt 1, err_cnt 0, h2c_match 1.
REQ-026 Same packet, byte 37 corrupted, qid 5 -> first_err_vld 1, qid 5, code 1, q5 err_cnt 1, h2c_match 0.
REQ-027 3-beat packet mty=10, txr_size 86, bad bytes in last 10 positions -> no error; txr_size 96 -> code 2.
REQ-028 Packet qid 9 with NUM_Q=8 -> code 4, no queue counter change; zero_byte packet on qid 1, txr_size 0 -> q1 pkt_cnt +1, no error.
REQ-029 control_reg[1]=1 -> tready follows LFSR exactly from reset; 100 packets all pass; clr_match coincident with tlast -> all status 0, no update.
REQ-030 axi_areset asserted mid-packet, then fresh packet -> pass, counters reflect only post-reset packet.
